// File: rtl/rsa_block_framer.sv
// ============================================================================
// rsa_block_framer
// ----------------------------------------------------------------------------
// Purpose:
//   Front end of the RSA modexp stage. This block takes a 512-bit AXI4-Stream
//   input beat and does the following:
//     - zeroes every byte whose tkeep bit is low,
//     - slices the masked beat into a low and a high 256-bit message block,
//     - emits those blocks one per 512-bit output beat. The block sits in
//       [255:0] and the upper half of the beat is zero.
//   A beat whose upper 32 byte enables are all low produces only the low
//   block. Otherwise it produces the low block first and then the high block.
//   tid is copied from the source beat to every block it produces. tlast is
//   carried by the final block of the beat.
//
// Configuration macro:
//   RSA_MOD_CHECK_EN - when defined, each block is compared against the
//                      modulus at input accept. A block >= modulus is
//                      replaced by zero when it is emitted. That emission
//                      also increments stat_drop_cnt and sets err_range.
//                      When undefined, no comparator is built, modulus is
//                      ignored, and the drop statistics stay at zero.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   modulus               RSA modulus, sampled at input accept
//   s_axis_*              512-bit input stream (tdata/tkeep/tvalid/tready/
//                         tlast/tid)
//   m_axis_*              512-bit output stream, one block per beat
//   stat_blk_cnt          emitted blocks, wraps
//   stat_drop_cnt         out-of-range blocks, saturates
//   err_range             sticky out-of-range flag, cleared only by reset
// ============================================================================
module rsa_block_framer #(
    parameter int TID_BITS = 6,
    parameter int BLK_BITS = 256
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [BLK_BITS-1:0] modulus,
    input  logic [511:0]        s_axis_tdata,
    input  logic [63:0]         s_axis_tkeep,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [TID_BITS-1:0] s_axis_tid,
    output logic [511:0]        m_axis_tdata,
    output logic [63:0]         m_axis_tkeep,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [TID_BITS-1:0] m_axis_tid,
    output logic [31:0]         stat_blk_cnt,
    output logic [15:0]         stat_drop_cnt,
    output logic                err_range
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT_LO = 2'd1,
        ST_EMIT_HI = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_s_tready;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [TID_BITS-1:0]   r_m_tid;
    logic [BLK_BITS-1:0]   r_m_blk;
    logic                  r_cur_drop;   // block currently presented is an out-of-range substitute
    logic [BLK_BITS-1:0]   r_hi_blk;     // second block of the beat, already substituted if dropped
    logic                  r_hi_last;
    logic                  r_hi_nz;
    logic                  r_hi_drop;
    logic [31:0]           r_blk_cnt;
    logic [15:0]           r_drop_cnt;
    logic                  r_err_range;

    logic [511:0]          w_masked;
    logic [BLK_BITS-1:0]   w_lo;
    logic [BLK_BITS-1:0]   w_hi;
    logic                  w_hi_nz;
    logic                  w_ge_lo;
    logic                  w_ge_hi;
    logic                  w_m_hs;

    // Saturating increment for the 16-bit drop statistic.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    // Byte-wise masking of the input beat: disabled bytes read as zero.
    always_comb begin
        w_masked = 512'd0;
        for (int k = 0; k < 64; k++) begin
            if (s_axis_tkeep[k]) begin
                w_masked[8*k +: 8] = s_axis_tdata[8*k +: 8];
            end else begin
                w_masked[8*k +: 8] = 8'h00;
            end
        end
    end

    assign w_lo    = w_masked[BLK_BITS-1:0];
    assign w_hi    = w_masked[2*BLK_BITS-1:BLK_BITS];
    assign w_hi_nz = |s_axis_tkeep[63:32];
    assign w_m_hs  = r_m_tvalid & m_axis_tready;

`ifdef RSA_MOD_CHECK_EN
    assign w_ge_lo = (w_lo >= modulus);
    assign w_ge_hi = (w_hi >= modulus);
`else
    logic w_unused_modulus;
    assign w_ge_lo          = 1'b0;
    assign w_ge_hi          = 1'b0;
    assign w_unused_modulus = ^modulus;
`endif

    // Framing FSM with registered stream outputs and statistics.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= ST_IDLE;
            r_s_tready  <= 1'b1;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tid     <= '0;
            r_m_blk     <= '0;
            r_cur_drop  <= 1'b0;
            r_hi_blk    <= '0;
            r_hi_last   <= 1'b0;
            r_hi_nz     <= 1'b0;
            r_hi_drop   <= 1'b0;
            r_blk_cnt   <= 32'd0;
            r_drop_cnt  <= 16'd0;
            r_err_range <= 1'b0;
        end else begin
            // Statistics follow the block that completes its handshake this cycle.
            if (w_m_hs) begin
                r_blk_cnt <= r_blk_cnt + 32'd1;
                if (r_cur_drop) begin
                    r_drop_cnt  <= sat_inc16(r_drop_cnt);
                    r_err_range <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        // Low block goes straight to the output. The high block is parked.
                        r_m_blk    <= w_ge_lo ? '0 : w_lo;
                        r_m_tlast  <= s_axis_tlast & ~w_hi_nz;
                        r_m_tid    <= s_axis_tid;
                        r_m_tvalid <= 1'b1;
                        r_s_tready <= 1'b0;
                        r_cur_drop <= w_ge_lo;
                        r_hi_blk   <= w_ge_hi ? '0 : w_hi;
                        r_hi_last  <= s_axis_tlast;
                        r_hi_nz    <= w_hi_nz;
                        r_hi_drop  <= w_ge_hi;
                        r_state    <= ST_EMIT_LO;
                    end
                end
                ST_EMIT_LO: begin
                    if (w_m_hs) begin
                        if (r_hi_nz) begin
                            r_m_blk    <= r_hi_blk;
                            r_m_tlast  <= r_hi_last;
                            r_cur_drop <= r_hi_drop;
                            r_state    <= ST_EMIT_HI;
                        end else begin
                            r_m_tvalid <= 1'b0;
                            r_s_tready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT_HI: begin
                    if (w_m_hs) begin
                        r_m_tvalid <= 1'b0;
                        r_s_tready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_m_tvalid <= 1'b0;
                    r_s_tready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign m_axis_tdata  = {{(512-BLK_BITS){1'b0}}, r_m_blk};
    assign m_axis_tkeep  = r_m_tvalid ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_0000;
    assign stat_blk_cnt  = r_blk_cnt;
    assign stat_drop_cnt = r_drop_cnt;
    assign err_range     = r_err_range;

endmodule

// File: tb/tb_rsa_block_framer.sv
module tb_rsa_block_framer;

    localparam int TIDW = 6;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [255:0]    modulus;
    logic [511:0]    s_axis_tdata;
    logic [63:0]     s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [TIDW-1:0] s_axis_tid;
    logic [511:0]    m_axis_tdata;
    logic [63:0]     m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [TIDW-1:0] m_axis_tid;
    logic [31:0]     stat_blk_cnt;
    logic [15:0]     stat_drop_cnt;
    logic            err_range;

    rsa_block_framer #(.TID_BITS(TIDW), .BLK_BITS(256)) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .modulus       (modulus),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .stat_blk_cnt  (stat_blk_cnt),
        .stat_drop_cnt (stat_drop_cnt),
        .err_range     (err_range)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [255:0]    blk;
        logic            last;
        logic [TIDW-1:0] tid;
        logic            drop;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] m_blk_cnt;
    logic [15:0] m_drop_cnt;
    logic        m_err;
    bit          started = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected block list for one accepted beat, built from the byte-level rules.
    task automatic model_accept();
        logic [511:0] msk;
        logic [255:0] lo, hi;
        logic         ge_lo, ge_hi;
        exp_t         e;
        for (int k = 0; k < 64; k++)
            msk[8*k +: 8] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
        lo = msk[255:0];
        hi = msk[511:256];
`ifdef RSA_MOD_CHECK_EN
        ge_lo = (lo >= modulus);
        ge_hi = (hi >= modulus);
`else
        ge_lo = 1'b0;
        ge_hi = 1'b0;
`endif
        e.blk  = ge_lo ? 256'd0 : lo;
        e.drop = ge_lo;
        e.tid  = s_axis_tid;
        e.last = (s_axis_tkeep[63:32] == 32'd0) ? s_axis_tlast : 1'b0;
        mq.push_back(e);
        if (s_axis_tkeep[63:32] != 32'd0) begin
            e.blk  = ge_hi ? 256'd0 : hi;
            e.drop = ge_hi;
            e.last = s_axis_tlast;
            mq.push_back(e);
        end
    endtask

    // Reference model: one accepted beat in flight at a time, one block leaves per output handshake.
    initial begin
        forever begin
            @(posedge ap_clk);
            if (ap_rst) begin
                mq.delete();
                m_blk_cnt  = 32'd0;
                m_drop_cnt = 16'd0;
                m_err      = 1'b0;
                started    = 1'b1;
            end else if (started) begin
                if (mq.size() != 0) begin
                    if (m_axis_tready) begin
                        exp_t e;
                        e = mq.pop_front();
                        m_blk_cnt++;
                        if (e.drop) begin
                            if (m_drop_cnt != 16'hFFFF) m_drop_cnt++;
                            m_err = 1'b1;
                        end
                    end
                end else if (s_axis_tvalid) begin
                    model_accept();
                end
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (started && !ap_rst) begin
                chk("s_tready", s_axis_tready, mq.size() == 0);
                chk("m_tvalid", m_axis_tvalid, mq.size() != 0);
                if (mq.size() != 0) begin
                    chk("m_tdata", m_axis_tdata, {256'd0, mq[0].blk});
                    chk("m_tlast", m_axis_tlast, mq[0].last);
                    chk("m_tid", m_axis_tid, mq[0].tid);
                    chk("m_tkeep", m_axis_tkeep, 64'h0000_0000_FFFF_FFFF);
                end else begin
                    chk("m_tkeep_idle", m_axis_tkeep, 64'd0);
                end
                chk("blk_cnt", stat_blk_cnt, m_blk_cnt);
                chk("drop_cnt", stat_drop_cnt, m_drop_cnt);
                chk("err_range", err_range, m_err);
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Presents one beat to an idle DUT. Returns 1 time unit after the accepting edge.
    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [TIDW-1:0] id);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tid    = id;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    logic [511:0] d_case1;
    logic [511:0] r_data;
    logic [63:0]  r_keep;
    int           drain;

    initial begin
        d_case1       = {{32{8'h5A}}, {32{8'hA5}}};
        ap_rst        = 1'b1;
        modulus       = 256'd0;
        s_axis_tdata  = 512'd0;
        s_axis_tkeep  = 64'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = '0;
        m_axis_tready = 1'b1;
        repeat (3) step();
        chk("rst_s_tready", s_axis_tready, 1'b1);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 512'd0);
        chk("rst_m_tkeep", m_axis_tkeep, 64'd0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_m_tid", m_axis_tid, 6'd0);
        chk("rst_blk_cnt", stat_blk_cnt, 32'd0);
        chk("rst_drop_cnt", stat_drop_cnt, 16'd0);
        chk("rst_err", err_range, 1'b0);
        ap_rst = 1'b0;
        step();

        // Case 1: full beat splits into two blocks.
        send(d_case1, {64{1'b1}}, 1'b1, 6'd3);
        chk("t1_b0_data", m_axis_tdata, {256'd0, {32{8'hA5}}});
        chk("t1_b0_last", m_axis_tlast, 1'b0);
        chk("t1_b0_tid", m_axis_tid, 6'd3);
        step();
        chk("t1_b1_data", m_axis_tdata, {256'd0, {32{8'h5A}}});
        chk("t1_b1_last", m_axis_tlast, 1'b1);
        chk("t1_b1_tid", m_axis_tid, 6'd3);
        step();
        chk("t1_done_valid", m_axis_tvalid, 1'b0);
        chk("t1_blk_cnt", stat_blk_cnt, 32'd2);

        // Case 2: partial low half.
        send({64{8'h11}}, 64'h0000_0000_00FF_FFFF, 1'b1, 6'd0);
        chk("t2_data", m_axis_tdata, {256'd0, 64'd0, {24{8'h11}}});
        chk("t2_last", m_axis_tlast, 1'b1);
        step();
        chk("t2_done_valid", m_axis_tvalid, 1'b0);
        chk("t2_blk_cnt", stat_blk_cnt, 32'd3);

        // Case 3: backpressure while the low block is presented.
        m_axis_tready = 1'b0;
        send(d_case1, {64{1'b1}}, 1'b1, 6'd3);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_data", m_axis_tdata, {256'd0, {32{8'hA5}}});
            chk("t3_hold_valid", m_axis_tvalid, 1'b1);
            chk("t3_hold_last", m_axis_tlast, 1'b0);
            chk("t3_hold_sready", s_axis_tready, 1'b0);
            step();
        end
        m_axis_tready = 1'b1;
        step();
        chk("t3_b1_data", m_axis_tdata, {256'd0, {32{8'h5A}}});
        step();
        chk("t3_blk_cnt", stat_blk_cnt, 32'd5);

        // Case 4: empty beat gives one zero block.
        send(d_case1, 64'd0, 1'b1, 6'd5);
        chk("t4_data", m_axis_tdata, 512'd0);
        chk("t4_last", m_axis_tlast, 1'b1);
        chk("t4_tid", m_axis_tid, 6'd5);
        step();
        chk("t4_done_valid", m_axis_tvalid, 1'b0);
        chk("t4_blk_cnt", stat_blk_cnt, 32'd6);

        // Case 5: all-ones block against the given modulus.
        modulus = 256'hF4F5E3D2C1B0A9876543210FEDCBA9876543210FEDCBA9876543210FEDCBA98;
        send({64{8'hFF}}, 64'h0000_0000_FFFF_FFFF, 1'b1, 6'd7);
`ifdef RSA_MOD_CHECK_EN
        chk("t5_data", m_axis_tdata, 512'd0);
`else
        chk("t5_data", m_axis_tdata, {256'd0, {32{8'hFF}}});
`endif
        chk("t5_last", m_axis_tlast, 1'b1);
        step();
        chk("t5_blk_cnt", stat_blk_cnt, 32'd7);
`ifdef RSA_MOD_CHECK_EN
        chk("t5_drop_cnt", stat_drop_cnt, 16'd1);
        chk("t5_err", err_range, 1'b1);
`else
        chk("t5_drop_cnt", stat_drop_cnt, 16'd0);
        chk("t5_err", err_range, 1'b0);
`endif

        // Case 6: reset while the high block is pending.
        send(d_case1, {64{1'b1}}, 1'b1, 6'd3);
        step();
        m_axis_tready = 1'b0;
        ap_rst        = 1'b1;
        step();
        ap_rst        = 1'b0;
        chk("t6_m_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_s_tready", s_axis_tready, 1'b1);
        chk("t6_blk_cnt", stat_blk_cnt, 32'd0);
        chk("t6_drop_cnt", stat_drop_cnt, 16'd0);
        chk("t6_err", err_range, 1'b0);
        m_axis_tready = 1'b1;
        step();

        // Randomized traffic checked by the per-cycle comparison.
        for (int i = 0; i < 3000; i++) begin
            for (int w = 0; w < 16; w++) r_data[32*w +: 32] = $urandom();
            for (int w = 0; w < 2; w++) r_keep[32*w +: 32] = $urandom();
            case ($urandom_range(0, 5))
                0: r_keep = {64{1'b1}};
                1: r_keep = 64'd0;
                2: r_keep = {32'd0, r_keep[31:0]};
                3: r_keep = {r_keep[63:32], 32'd0};
                4: r_keep = {32'd0, {32{1'b1}}};
                default: r_keep = r_keep;
            endcase
            for (int w = 0; w < 8; w++) modulus[32*w +: 32] = $urandom();
            s_axis_tdata  = r_data;
            s_axis_tkeep  = r_keep;
            s_axis_tlast  = 1'($urandom_range(0, 1));
            s_axis_tid    = 6'($urandom_range(0, 63));
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            ap_rst        = ($urandom_range(0, 499) == 0);
            step();
        end
        ap_rst        = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        drain = 0;
        while (mq.size() != 0 && drain < 10) begin
            step();
            drain++;
        end
        chk("drain_empty", mq.size() == 0, 1'b1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
